// File: rtl/beat_timing_generator.sv
// Single-clock beat timing generator: digit pulses, blackout, store strobe, scan/action halver.
// Define TIMING_SINGLE_SHOT_EN to let `step` run exactly one beat from the stopped state.
module beat_timing_generator #(
  parameter  int unsigned DIGITS    = 32,
  parameter  int unsigned BO_DIGITS = 4,
  parameter  int unsigned DIV       = 4,
  parameter  int unsigned BEATS     = 4,
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              w_CLK,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic [DIGITS-1:0] ps,
  output logic              dot_ce,
  output logic              bo,
  output logic              nbo,
  output logic              xtb,
  output logic              ha,
  output logic              hs,
  output logic [BEAT_W-1:0] beat,
  output logic              beat_start,
  output logic              stopped
);

  localparam int unsigned TOTAL_DIGITS = DIGITS + BO_DIGITS;
  localparam int unsigned SUB_W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DIGIT_W      = (TOTAL_DIGITS > 1) ? $clog2(TOTAL_DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t               state_q, state_n;
  logic [SUB_W-1:0]     sub_q, sub_n;
  logic [DIGIT_W-1:0]   digit_q, digit_n;
  logic [BEAT_W-1:0]    beat_q, beat_n;

  logic running;
  logic sub_last;
  logic digit_last;
  logic beat_last;
  logic beat_end;
  logic start_single;

  assign running    = (state_q != ST_STOPPED);
  assign sub_last   = (sub_q == SUB_W'(DIV - 1));
  assign digit_last = (digit_q == DIGIT_W'(TOTAL_DIGITS - 1));
  assign beat_last  = (beat_q == BEAT_W'(BEATS - 1));
  assign beat_end   = sub_last && digit_last;

`ifdef TIMING_SINGLE_SHOT_EN
  assign start_single = step;
`else
  logic unused_step;
  assign unused_step  = step;
  assign start_single = 1'b0;
`endif

  // State and counter registers; reset returns to an idle generator at beat 0.
  always_ff @(posedge w_CLK) begin
    if (reset) begin
      state_q <= ST_STOPPED;
      sub_q   <= '0;
      digit_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_n;
      sub_q   <= sub_n;
      digit_q <= digit_n;
      beat_q  <= beat_n;
    end
  end

  // Next state and counter advance; counters hold at zero while stopped.
  always_comb begin
    state_n = state_q;
    sub_n   = sub_q;
    digit_n = digit_q;
    beat_n  = beat_q;

    if (running) begin
      sub_n = sub_last ? '0 : sub_q + SUB_W'(1);
      if (sub_last) begin
        digit_n = digit_last ? '0 : digit_q + DIGIT_W'(1);
      end
      if (beat_end) begin
        beat_n = beat_last ? '0 : beat_q + BEAT_W'(1);
      end
    end

    unique case (state_q)
      ST_STOPPED: begin
        if (run) begin
          state_n = ST_RUN;
        end else if (start_single) begin
          state_n = ST_STOPPING;
        end
      end
      ST_RUN: begin
        // A drop of run on the final cycle of a beat stops right at that boundary.
        if (!run) begin
          state_n = beat_end ? ST_STOPPED : ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (run) begin
          state_n = ST_RUN;
        end else if (beat_end) begin
          state_n = ST_STOPPED;
        end
      end
      default: state_n = ST_STOPPED;
    endcase
  end

  // Output decode straight from registered state, no added latency.
  always_comb begin
    ps = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      ps[d] = running && (digit_q == DIGIT_W'(d));
    end
    bo         = running && (32'(digit_q) >= DIGITS);
    nbo        = running && !bo;
    dot_ce     = running && sub_last;
    beat_start = running && (sub_q == '0) && (digit_q == '0);
    ha         = running && beat_q[0];
    hs         = running && !beat_q[0];
    xtb        = bo && ha;
    beat       = beat_q;
    stopped    = !running;
  end

endmodule

// File: tb/tb_beat_timing_generator.sv
// Directed bench for beat_timing_generator at default parameters.
// Every output is compared each cycle against a cycle-index model of the beat.
module tb_beat_timing_generator;

  localparam int unsigned DIGITS    = 32;
  localparam int unsigned BO_DIGITS = 4;
  localparam int unsigned DIV       = 4;
  localparam int unsigned BEATS     = 4;
  localparam int          BEAT_LEN  = (DIGITS + BO_DIGITS) * DIV;

  logic        w_CLK = 1'b0;
  logic        reset;
  logic        run;
  logic        step;
  logic [31:0] ps;
  logic        dot_ce, bo, nbo, xtb, ha, hs, beat_start, stopped;
  logic [1:0]  beat;

  int checks = 0;
  int fails  = 0;

  always #5 w_CLK = ~w_CLK;

  beat_timing_generator #(
    .DIGITS(DIGITS), .BO_DIGITS(BO_DIGITS), .DIV(DIV), .BEATS(BEATS)
  ) dut (
    .w_CLK(w_CLK), .reset(reset), .run(run), .step(step),
    .ps(ps), .dot_ce(dot_ce), .bo(bo), .nbo(nbo), .xtb(xtb),
    .ha(ha), .hs(hs), .beat(beat), .beat_start(beat_start), .stopped(stopped)
  );

  logic [41:0] obs;
  assign obs = {ps, dot_ce, bo, nbo, xtb, ha, hs, beat, beat_start, stopped};

  // Expected output vector for cycle c of beat b (r=0 means stopped, showing beat b next).
  function automatic logic [41:0] exp_vec(input bit r, input int b, input int c);
    logic [31:0] one;
    logic [31:0] p;
    logic [1:0]  bi;
    logic        bo_e;
    int          d, s;
    one = 32'd1;
    bi  = 2'(b);
    d   = c / int'(DIV);
    s   = c % int'(DIV);
    if (!r) return {32'd0, 6'd0, bi, 1'b0, 1'b1};
    p    = (d < int'(DIGITS)) ? (one << d) : 32'd0;
    bo_e = (d >= int'(DIGITS));
    return {p, 1'(s == int'(DIV) - 1), bo_e, ~bo_e, bo_e & bi[0], bi[0], ~bi[0], bi,
            1'(c == 0), 1'b0};
  endfunction

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(0, 0, 0)) begin
        fails++;
        $display("FAIL reset i=%0d got %h expected %h", i, obs, exp_vec(0, 0, 0));
      end
    end
    run = 1'b0; step = 1'b0;
  endtask

  task automatic test_first_beat();
    reset = 1'b0; run = 1'b1;
    for (int c = 0; c < BEAT_LEN; c++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(1, 0, c)) begin
        fails++;
        $display("FAIL first_beat c=%0d got %h expected %h", c, obs, exp_vec(1, 0, c));
      end
    end
  endtask

  task automatic test_continuous();
    for (int b = 1; b <= 4; b++) begin
      int dots = 0;
      for (int c = 0; c < BEAT_LEN; c++) begin
        @(negedge w_CLK);
        dots += int'(dot_ce);
        checks++;
        if (obs !== exp_vec(1, b % 4, c)) begin
          fails++;
          $display("FAIL continuous b=%0d c=%0d got %h expected %h", b, c, obs, exp_vec(1, b % 4, c));
        end
        checks++;
        if (!$onehot0(ps)) begin
          fails++;
          $display("FAIL ps_onehot b=%0d c=%0d got %h expected at most one bit", b, c, ps);
        end
      end
      checks++;
      if (dots != 36) begin
        fails++;
        $display("FAIL dot_count b=%0d got %0d expected 36", b, dots);
      end
    end
  endtask

  task automatic test_stop_mid_beat();
    for (int b = 1; b <= 2; b++) begin
      for (int c = 0; c < BEAT_LEN; c++) begin
        @(negedge w_CLK);
        checks++;
        if (obs !== exp_vec(1, b, c)) begin
          fails++;
          $display("FAIL stop_drain b=%0d c=%0d got %h expected %h", b, c, obs, exp_vec(1, b, c));
        end
        if (b == 2 && c == 20) run = 1'b0;
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(0, 3, 0)) begin
        fails++;
        $display("FAIL stopped_idle i=%0d got %h expected %h", i, obs, exp_vec(0, 3, 0));
      end
    end
    run = 1'b1;
    for (int c = 0; c < BEAT_LEN; c++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(1, 3, c)) begin
        fails++;
        $display("FAIL resume c=%0d got %h expected %h", c, obs, exp_vec(1, 3, c));
      end
    end
  endtask

  task automatic test_no_gap();
    for (int c = 0; c < BEAT_LEN; c++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(1, 0, c)) begin
        fails++;
        $display("FAIL no_gap c=%0d got %h expected %h", c, obs, exp_vec(1, 0, c));
      end
      if (c == 10) run = 1'b0;
      if (c == 50) run = 1'b1;
    end
  endtask

  task automatic test_reset_mid_beat();
    for (int c = 0; c <= 80; c++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(1, 1, c)) begin
        fails++;
        $display("FAIL pre_reset c=%0d got %h expected %h", c, obs, exp_vec(1, 1, c));
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(0, 0, 0)) begin
        fails++;
        $display("FAIL mid_reset i=%0d got %h expected %h", i, obs, exp_vec(0, 0, 0));
      end
    end
    reset = 1'b0;
    for (int c = 0; c < BEAT_LEN; c++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(1, 0, c)) begin
        fails++;
        $display("FAIL post_reset c=%0d got %h expected %h", c, obs, exp_vec(1, 0, c));
      end
    end
  endtask

  task automatic test_step();
    for (int c = 0; c < BEAT_LEN; c++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(1, 1, c)) begin
        fails++;
        $display("FAIL step_drain c=%0d got %h expected %h", c, obs, exp_vec(1, 1, c));
      end
      if (c == 30) run = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge w_CLK);
      checks++;
      if (obs !== exp_vec(0, 2, 0)) begin
        fails++;
        $display("FAIL step_idle i=%0d got %h expected %h", i, obs, exp_vec(0, 2, 0));
      end
    end
    step = 1'b1;
    @(negedge w_CLK);
    step = 1'b0;
`ifdef TIMING_SINGLE_SHOT_EN
    for (int c = 0; c < BEAT_LEN; c++) begin
      checks++;
      if (obs !== exp_vec(1, 2, c)) begin
        fails++;
        $display("FAIL single_beat c=%0d got %h expected %h", c, obs, exp_vec(1, 2, c));
      end
      @(negedge w_CLK);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_vec(0, 3, 0)) begin
        fails++;
        $display("FAIL single_done i=%0d got %h expected %h", i, obs, exp_vec(0, 3, 0));
      end
      @(negedge w_CLK);
    end
`else
    for (int i = 0; i < BEAT_LEN + 4; i++) begin
      checks++;
      if (obs !== exp_vec(0, 2, 0)) begin
        fails++;
        $display("FAIL step_ignored i=%0d got %h expected %h", i, obs, exp_vec(0, 2, 0));
      end
      @(negedge w_CLK);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t got timeout expected completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_beat();
    test_continuous();
    test_stop_mid_beat();
    test_no_gap();
    test_reset_mid_beat();
    test_step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/beat_timing_generator.md
Name: beat_timing_generator

Overview:
- Parametrised, single-clock successor to the divider / blackout / halver / digit-pulse chain.
- Generates the full beat timing from one master clock:
  - one-hot digit pulses
  - blackout (flyback)
  - write strobe
  - scan/action halver
  - beat index and beat-start strobe
- Uses clock enables only, never derived clocks.
- Adds run/stop control halting cleanly at beat boundaries; feeds store, accumulator and control sequencing.

Parameters:
- DIGITS, 32, digit periods per beat carrying data (width of ps).
- BO_DIGITS, 4, blackout digit periods appended after the data digits.
- DIV, 4, w_CLK cycles per digit period (>=2).
- BEATS, 4, beats per instruction cycle (even, >=2); even beat = scan, odd beat = action.

Ports:
- w_CLK  in  1  master clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = generate beats, 0 = stop at the next beat boundary.
- step  in  1  single-beat request (used only with TIMING_SINGLE_SHOT_EN).
- ps  out  DIGITS  one-hot digit pulses, ps[d] high for all of digit period d.
- dot_ce  out  1  one-cycle enable in the last w_CLK of every digit period.
- bo / nbo  out  1  blackout and its complement (nbo = ~bo while running, 0 when stopped).
- xtb  out  1  store write strobe = bo & ha.
- ha / hs  out  1  action / scan halver levels.
- beat  out  max(1,clog2(BEATS))  current beat index.
- beat_start  out  1  one-cycle strobe on the first w_CLK of each beat.
- stopped  out  1  generator idle.

Behaviour:
- Counters:
  - sub: 0..DIV-1
  - digit: 0..DIGITS+BO_DIGITS-1
  - beat: 0..BEATS-1
  - Widths are clog2 of range, minimum 1.
- Advance (RUN state only):
  - sub increments each cycle.
  - sub wraps at DIV-1 and advances digit.
  - digit wraps at DIGITS+BO_DIGITS-1 and advances beat.
  - beat wraps BEATS-1 -> 0.
- Beat length = (DIGITS+BO_DIGITS)*DIV cycles (defaults: 144).
- Output decode is registered-state combinational, with no extra latency:
  - ps[d] = running & digit==d & d<DIGITS
  - bo = running & digit>=DIGITS
  - dot_ce = running & sub==DIV-1
  - beat_start = running & sub==0 & digit==0
  - ha = running & beat[0]
  - hs = running & ~beat[0]
- States: STOPPED, RUN, STOPPING.
  - STOPPED -> RUN: run=1 at an edge; counters already 0; beat_start asserted the following cycle.
  - RUN -> STOPPING: run=0 sampled.
  - STOPPING -> RUN: run re-asserted before the beat ends; no gap.
  - STOPPING behaves as RUN but enters STOPPED at the wrap of the last digit of the current beat.
  - STOPPED holds: sub=0, digit=0, beat index = next beat to run. All timing outputs are 0, stopped=1.
- A beat is never truncated by run: once begun, it completes all DIGITS+BO_DIGITS periods.
- Reset (synchronous, any time including mid-beat): state STOPPED, sub=0, digit=0, beat=0. All outputs 0 except stopped=1. Reset dominates run and step.
- ps is strictly one-hot or zero; never two bits set.
- BEATS=2 degenerates to the classic alternating scan/action halver.

Optional Feature:
- TIMING_SINGLE_SHOT_EN defined:
  - step=1 sampled while STOPPED and run=0 executes exactly one beat (STOPPED -> STOPPING), then returns to STOPPED with beat incremented.
  - step is ignored in RUN/STOPPING.
  - step held high produces one beat per STOPPED entry (level re-sampled after each stop).
- Macro undefined: the step port exists but is ignored; only run controls starting.

Test Plan:
- Reset then run=1 (defaults) -> beat_start the cycle after run sampled. ps[0] high 4 cycles, then ps[1]..ps[31]. bo high cycles 128..143. Next beat_start at cycle 144; beat=1, ha=1, xtb=1 during its bo.
- Run continuously 4 beats -> beat sequence 0,1,2,3,0. hs,ha alternate. Exactly 36 dot_ce per beat. ps never multi-hot (assertion).
- Drop run at digit 5 of beat 2 -> beat 2 completes (bo for 16 cycles), then stopped=1, beat=3, all timing outputs 0. Raise run -> resumes at beat 3 digit 0.
- Pulse run low then high within one beat -> no gap; beat_start spacing stays 144.
- Assert reset at digit 20 of beat 1 -> next cycle stopped=1, ps=0, beat=0. Release with run=1 -> beat 0 starts cleanly.
- TIMING_SINGLE_SHOT_EN, DIGITS=8, BO_DIGITS=2, DIV=2, run=0, step pulse -> exactly one 20-cycle beat, then stopped, beat 0->1. Without the macro the same stimulus leaves stopped=1 throughout.
